// File: rtl/s27_bist_pkg.sv
// s27 BIST shared types, widths, tap masks and step functions.
// Used by s27_bist_ctrl and s27_bist_misr.
package s27_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN,
    DONE
  } bist_state_t;

  localparam int LFSR_W = 8;
  localparam int MISR_W = 16;

  // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
  // feedback from bits 15,14,12,3
  localparam logic [MISR_W-1:0] MISR_TAPS = 16'hD008;

  function automatic logic [LFSR_W-1:0] lfsr_step(
    input logic [LFSR_W-1:0] l
  );
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic logic [MISR_W-1:0] misr_step(
    input logic [MISR_W-1:0] m,
    input logic              d
  );
    return {m[MISR_W-2:0], ^(m & MISR_TAPS)}
         ^ {{(MISR_W-1){1'b0}}, d};
  endfunction

endpackage

// File: rtl/s27_bist_misr.sv
// 16-bit MISR with synchronous clear, enable and 1-bit serial input.
// Ports: clk, rst (async high), clr, en, din -> sig (current signature).
module s27_bist_misr
  import s27_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [MISR_W-1:0] sig
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sig <= '0;
    else if (clr)
      sig <= '0;
    else if (en)
      sig <= misr_step(sig, din);
  end

endmodule

// File: rtl/s27_bist_ctrl.sv
// Self-test sequencer for the s27 core: LFSR stimulus on G0..G3, MISR
// compaction of G17, golden compare. Optional init phase: S27_BIST_INIT_EN.
// Ports: CK, RST (async high), start, dut_out -> dut_in[3:0], busy, done,
//        pass, signature[15:0].
module s27_bist_ctrl
  import s27_bist_pkg::*;
#(
  parameter logic [15:0]       NUM_PATTERNS = 16'd16,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 8'h01,
  parameter logic [MISR_W-1:0] GOLDEN_SIG   = 16'h0000,
  parameter logic [15:0]       INIT_CYCLES  = 16'd4
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic              dut_out,
  output logic [3:0]        dut_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  bist_state_t       state, nstate;
  logic [LFSR_W-1:0] lfsr, lfsr_d;
  logic [15:0]       cnt, cnt_d;
  logic              pass_d;
  logic [3:0]        din_d;
  logic              misr_clr, misr_en;

  always_comb begin
    nstate   = state;
    lfsr_d   = lfsr;
    cnt_d    = cnt;
    pass_d   = pass;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          pass_d   = 1'b0;
          misr_clr = 1'b1;
          cnt_d    = '0;
`ifdef S27_BIST_INIT_EN
          nstate   = INIT;
`else
          nstate   = RUN;
          lfsr_d   = LFSR_SEED;
`endif
        end
      end
      INIT: begin
        if (cnt == INIT_CYCLES - 16'd1) begin
          nstate = RUN;
          cnt_d  = '0;
          lfsr_d = LFSR_SEED;
        end else begin
          cnt_d  = cnt + 16'd1;
        end
      end
      RUN: begin
        misr_en = 1'b1;
        lfsr_d  = lfsr_step(lfsr);
        if (cnt == NUM_PATTERNS - 16'd1) begin
          nstate = DONE;
          // compare the value the MISR takes on this same edge
          pass_d = misr_step(signature, dut_out) == GOLDEN_SIG;
        end else begin
          cnt_d  = cnt + 16'd1;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // registered stimulus follows the state/LFSR value being loaded
  always_comb begin
    din_d = 4'h0;
    unique case (1'b1)
      nstate == RUN:  din_d = lfsr_d[3:0];
      nstate == INIT: din_d = 4'h1;
      default:        din_d = 4'h0;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      lfsr   <= LFSR_SEED;
      cnt    <= '0;
      dut_in <= 4'h0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else begin
      state  <= nstate;
      lfsr   <= lfsr_d;
      cnt    <= cnt_d;
      dut_in <= din_d;
      busy   <= (nstate == RUN) || (nstate == INIT);
      done   <= nstate == DONE;
      pass   <= pass_d;
    end
  end

  s27_bist_misr u_misr (
    .clk (CK),
    .rst (RST),
    .clr (misr_clr),
    .en  (misr_en),
    .din (dut_out),
    .sig (signature)
  );

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Bench for s27_bist_ctrl: vector table, hand sequences, random runs
// against an arithmetic LFSR/MISR reference model.
module tb_s27_bist_ctrl;

  localparam int NP   = 16;
  localparam int SEED = 1;
`ifdef S27_BIST_INIT_EN
  localparam int INITC = 4;
`else
  localparam int INITC = 0;
`endif

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0, start1 = 1'b0;
  logic        dout = 1'b0, dout1 = 1'b0;
  logic [3:0]  din0, din1;
  logic        busy0, busy1, done0, done1, pass0, pass1;
  logic [15:0] sig0, sig1;

  int nchk = 0;
  int nerr = 0;

  always #5 CK = ~CK;

  s27_bist_ctrl #(
    .NUM_PATTERNS (16'd16),
    .LFSR_SEED    (8'h01),
    .GOLDEN_SIG   (16'h0000),
    .INIT_CYCLES  (16'd4)
  ) u_dut (
    .CK (CK), .RST (RST), .start (start), .dut_out (dout),
    .dut_in (din0), .busy (busy0), .done (done0), .pass (pass0),
    .signature (sig0)
  );

  s27_bist_ctrl #(
    .NUM_PATTERNS (16'd1),
    .LFSR_SEED    (8'h01),
    .GOLDEN_SIG   (16'h0000),
    .INIT_CYCLES  (16'd4)
  ) u_dut1 (
    .CK (CK), .RST (RST), .start (start1), .dut_out (dout1),
    .dut_in (din1), .busy (busy1), .done (done1), .pass (pass1),
    .signature (sig1)
  );

  typedef struct {
    int         cyc;
    logic [3:0] din;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int lfsr_nx(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l * 2) % 256) + fb;
  endfunction

  function automatic int misr_nx(input int m, input int b);
    int fb;
    fb = ((m >> 15) ^ (m >> 14) ^ (m >> 12) ^ (m >> 3)) & 1;
    return (((m * 2) % 65536) + fb) ^ b;
  endfunction

  task automatic reset_chk(input string tag);
    chk({tag, "_din"},  din0,  0);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_pass"}, pass0, 0);
    chk({tag, "_sig"},  sig0,  0);
    chk({tag, "_sig1"}, sig1,  0);
    chk({tag, "_done1"}, done1, 0);
  endtask

  // dmode 0: random responses, 1: all zero; spur = RUN cycle with a
  // stray start (-1 none)
  task automatic do_run(input int dmode, input int spur);
    int l, m, b;
    l = SEED;
    m = 0;
    start = 1'b1;
    dout  = 1'b0;
    @(negedge CK);
    start = 1'b0;
    chk("restart_done", done0, 0);
    for (int i = 0; i < INITC; i++) begin
      chk("init_din", din0, 1);
      chk("init_busy", busy0, 1);
      @(negedge CK);
    end
    for (int k = 0; k < NP; k++) begin
      chk("run_din", din0, l % 16);
      chk("run_busy", busy0, 1);
      chk("run_done", done0, 0);
      b = (dmode == 0) ? int'($urandom_range(0, 1)) : 0;
      dout  = b[0];
      start = (k == spur);
      m = misr_nx(m, b);
      l = lfsr_nx(l);
      @(negedge CK);
      start = 1'b0;
    end
    chk("end_done", done0, 1);
    chk("end_busy", busy0, 0);
    chk("end_sig",  sig0,  m);
    chk("end_pass", pass0, m == 0);
    chk("end_din",  din0,  0);
    @(negedge CK);
    chk("hold_sig",  sig0,  m);
    chk("hold_done", done0, 1);
  endtask

  initial begin
    tbl[0] = '{0,  4'h0, 1'b0, 1'b0};
    tbl[1] = '{1,  4'h1, 1'b1, 1'b0};
    tbl[2] = '{2,  4'h2, 1'b1, 1'b0};
    tbl[3] = '{3,  4'h4, 1'b1, 1'b0};
    tbl[4] = '{4,  4'h8, 1'b1, 1'b0};
    tbl[5] = '{5,  4'h1, 1'b1, 1'b0};
    tbl[6] = '{16, 4'h0, 1'b1, 1'b0};
    tbl[7] = '{17, 4'h0, 1'b0, 1'b1};

    #2;
    reset_chk("rst");
    @(negedge CK);
    RST = 1'b0;
    @(negedge CK);

    // vector table, all-zero response
    for (int c = 0; c <= NP + 1 + INITC; c++) begin
      start = (c == 0);
      foreach (tbl[j]) begin
        if (tbl[j].cyc + ((tbl[j].cyc > 0) ? INITC : 0) == c) begin
          if (tbl[j].cyc <= 5 && tbl[j].cyc != 0)
            chk($sformatf("tbl_din%0d", tbl[j].cyc), din0, tbl[j].din);
          chk($sformatf("tbl_busy%0d", tbl[j].cyc), busy0, tbl[j].busy);
          chk($sformatf("tbl_done%0d", tbl[j].cyc), done0, tbl[j].done);
        end
      end
      @(negedge CK);
      start = 1'b0;
    end
    chk("zero_sig",  sig0,  0);
    chk("zero_pass", pass0, 1);

    // single pattern, response tied high
    start1 = 1'b1;
    dout1  = 1'b1;
    @(negedge CK);
    start1 = 1'b0;
    for (int i = 0; i < INITC; i++) @(negedge CK);
    chk("np1_busy", busy1, 1);
    chk("np1_din",  din1,  1);
    @(negedge CK);
    chk("np1_done", done1, 1);
    chk("np1_sig",  sig1,  1);
    chk("np1_pass", pass1, 0);
    dout1 = 1'b0;

    do_run(0, -1);
    do_run(0, 5);
    do_run(0, NP - 1);
    do_run(1, 2);

    // asynchronous reset part-way through a run
    start = 1'b1;
    dout  = 1'b1;
    @(negedge CK);
    start = 1'b0;
    repeat (3 + INITC) @(negedge CK);
    #2;
    RST = 1'b1;
    #1;
    reset_chk("midrst");
    @(negedge CK);
    RST  = 1'b0;
    dout = 1'b0;
    @(negedge CK);
    reset_chk("postrst");

    do_run(0, -1);
    do_run(0, -1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
